uart_cmd_rcv: RTL and testbench



---
 rtl/uart_cmd_rcv_if.sv | 32 +++
 rtl/uart_cmd_rcv.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_cmd_rcv.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rcv_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rcv_if
// Description : Command handshake bundle between the UART command receiver
//               (master, producer) and the command processor (slave).
//   cmd         [15:0]  assembled command {high byte, low byte}
//   cmd_rdy             command valid flag
//   clr_cmd_rdy         consumer acknowledge, clears cmd_rdy
//   frm_err             one-cycle framing / timeout error pulse
// Revision    : 1.0  initial release
// ============================================================================
interface uart_cmd_rcv_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frm_err;

  modport master (
    output cmd,
    output cmd_rdy,
    output frm_err,
    input  clr_cmd_rdy
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    input  frm_err,
    output clr_cmd_rdy
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rcv.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rcv
// Description : Serial command front end. Receives 8N1 UART frames on RX and
//               pairs two consecutive bytes (high first) into a 16-bit
//               command presented with a ready/clear handshake.
// Ports       :
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   RX      in   asynchronous serial line, idles high
//   cmd_if  master modport of uart_cmd_rcv_if (cmd, cmd_rdy, frm_err out;
//           clr_cmd_rdy in)
// Parameters  :
//   BAUD_DIV  clk cycles per bit (>= 8)
//   TIMEOUT   inter-byte timeout in clk cycles
// Options     :
//   UART_CMD_TIMEOUT_EN  when defined, a lone high byte is dropped after
//                        TIMEOUT idle clocks and frm_err pulses.
// Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_rcv #(
  parameter int BAUD_DIV = 5208,
  parameter int TIMEOUT  = 2500000
) (
  input wire             clk,
  input wire             rst_n,
  input wire             RX,
  uart_cmd_rcv_if.master cmd_if
);

  localparam int c_baud_w = $clog2(BAUD_DIV + 1);
  localparam logic [c_baud_w-1:0] c_baud_full = c_baud_w'(BAUD_DIV);
  localparam logic [c_baud_w-1:0] c_baud_half = c_baud_w'(BAUD_DIV / 2);
  localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } bit_state_t;

  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } byte_state_t;

  // --------------------------------------------------------------------------
  // RX synchronizer and falling-edge detect. Preset high so that reset
  // release never looks like a start bit.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;
  logic w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // --------------------------------------------------------------------------
  // Bit FSM
  // --------------------------------------------------------------------------
  bit_state_t            r_bit_st;
  bit_state_t            w_bit_nxt;
  logic [c_baud_w-1:0]   r_baud_cnt;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  w_expire;
  logic                  w_cnt_load;
  logic [c_baud_w-1:0]   w_cnt_val;
  logic                  w_start_ok;
  logic                  w_byte_done;
  logic                  w_stop_err;

  // A counter loaded with N expires N cycles later.
  assign w_expire = (r_baud_cnt == c_baud_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bit_st <= IDLE;
    else        r_bit_st <= w_bit_nxt;
  end

  always_comb begin
    w_bit_nxt   = r_bit_st;
    w_cnt_load  = 1'b0;
    w_cnt_val   = c_baud_full;
    w_start_ok  = 1'b0;
    w_byte_done = 1'b0;
    w_stop_err  = 1'b0;
    case (r_bit_st)
      IDLE: begin
        if (w_fall) begin
          // Half a bit puts every later sample mid-bit.
          w_cnt_load = 1'b1;
          w_cnt_val  = c_baud_half;
          w_bit_nxt  = START;
        end
      end
      START: begin
        if (w_expire) begin
          if (r_rx_sync) begin
            w_bit_nxt = IDLE;
          end else begin
            w_start_ok = 1'b1;
            w_cnt_load = 1'b1;
            w_bit_nxt  = DATA;
          end
        end
      end
      DATA: begin
        if (w_expire) begin
          w_cnt_load = 1'b1;
          if (r_bit_cnt == 3'd7) w_bit_nxt = STOP;
        end
      end
      STOP: begin
        if (w_expire) begin
          // Back to IDLE at the sample point so an immediately following
          // start edge is not missed.
          w_bit_nxt = IDLE;
          if (r_rx_sync) w_byte_done = 1'b1;
          else           w_stop_err  = 1'b1;
        end
      end
      default: w_bit_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      if (w_cnt_load)
        r_baud_cnt <= w_cnt_val;
      else if (r_baud_cnt != '0)
        r_baud_cnt <= r_baud_cnt - c_baud_one;

      if (w_start_ok)
        r_bit_cnt <= 3'd0;
      else if ((r_bit_st == DATA) && w_expire)
        r_bit_cnt <= r_bit_cnt + 3'd1;

      // LSB arrives first, so shift in from the top.
      if ((r_bit_st == DATA) && w_expire)
        r_shift <= {r_rx_sync, r_shift[7:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Optional inter-byte timeout
  // --------------------------------------------------------------------------
  byte_state_t r_byte_st;
  byte_state_t w_byte_nxt;
  logic        w_hold_cap;
  logic        w_cmd_upd;
  logic        w_to_hit;
  logic        w_to_fire;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT);
  localparam logic [c_to_w-1:0] c_to_one = c_to_w'(1);

  logic [c_to_w-1:0] r_to_cnt;

  // Counts only idle line time in WAIT_LO; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_to_cnt <= '0;
    else if (w_hold_cap)
      r_to_cnt <= '0;
    else if ((r_byte_st == WAIT_LO) && (r_bit_st == IDLE) && (r_to_cnt != c_to_max))
      r_to_cnt <= r_to_cnt + c_to_one;
  end

  assign w_to_hit = (r_byte_st == WAIT_LO) && (r_to_cnt == c_to_max);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_to_hit         = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Byte-pairing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_byte_st <= WAIT_HI;
    else        r_byte_st <= w_byte_nxt;
  end

  always_comb begin
    w_byte_nxt = r_byte_st;
    w_hold_cap = 1'b0;
    w_cmd_upd  = 1'b0;
    w_to_fire  = 1'b0;
    case (r_byte_st)
      WAIT_HI: begin
        if (w_byte_done) begin
          w_hold_cap = 1'b1;
          w_byte_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A completed byte takes precedence over a coincident timeout.
        if (w_byte_done) begin
          w_cmd_upd  = 1'b1;
          w_byte_nxt = WAIT_HI;
        end else if (w_to_hit) begin
          w_to_fire  = 1'b1;
          w_byte_nxt = WAIT_HI;
        end
      end
      default: w_byte_nxt = WAIT_HI;
    endcase
  end

  // --------------------------------------------------------------------------
  // Hold register, command output and handshake
  // --------------------------------------------------------------------------
  logic [7:0]  r_hold;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        r_frm_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= 8'h00;
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_hold_cap)
        r_hold <= r_shift;
      else if (w_to_fire)
        r_hold <= 8'h00;

      // cmd only moves on a complete pair, so it is stable while the next
      // high byte is in flight.
      if (w_cmd_upd)
        r_cmd <= {r_hold, r_shift};

      // Set beats clear when both land in the same cycle.
      if (w_cmd_upd)
        r_cmd_rdy <= 1'b1;
      else if (cmd_if.clr_cmd_rdy || (w_start_ok && (r_byte_st == WAIT_HI)))
        r_cmd_rdy <= 1'b0;

      r_frm_err <= w_stop_err | w_to_fire;
    end
  end

  assign cmd_if.cmd     = r_cmd;
  assign cmd_if.cmd_rdy = r_cmd_rdy;
  assign cmd_if.frm_err = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rcv.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_rcv
// Description : Directed self-checking bench for uart_cmd_rcv with
//               BAUD_DIV=16 and TIMEOUT=200. Expected results for the
//               timeout scenario follow UART_CMD_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_rcv;

  localparam int BAUD_DIV = 16;
  localparam int TIMEOUT  = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic RX    = 1'b1;

  int checks = 0;
  int errors = 0;

  int cyc          = 0;
  int frm_cnt      = 0;
  int rise_cnt     = 0;
  int rise_cyc     = 0;
  int rdy_high_cnt = 0;
  logic prev_rdy   = 1'b0;

  uart_cmd_rcv_if bus ();

  uart_cmd_rcv #(
    .BAUD_DIV (BAUD_DIV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .cmd_if (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.frm_err === 1'b1) frm_cnt++;
    if (bus.cmd_rdy === 1'b1) rdy_high_cnt++;
    if (bus.cmd_rdy === 1'b1 && prev_rdy !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_rdy = bus.cmd_rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_bit(input logic v);
    RX = v;
    wait_cycles(BAUD_DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int start);
    @(posedge clk);
    #1;
    start = cyc;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
    RX = 1'b1;
  endtask

  initial begin
    int s;
    int r0;
    int f0;
    int h0;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
    int          exp_to;

    bus.clr_cmd_rdy = 1'b0;

    // Reset state
    wait_cycles(3);
    check("reset_cmd", bus.cmd, 16'h0000);
    check("reset_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("reset_frm_err", bus.frm_err, 1'b0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Nominal command 0xA5, 0x3C
    r0 = rise_cnt;
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h3C, 1'b1, s);
    wait_cycles(10);
    check("nom_rise_once", rise_cnt - r0, 1);
    check("nom_rise_in_stop_bit",
          ((rise_cyc >= s + 145) && (rise_cyc <= s + 165)) ? 1 : 0, 1);
    check("nom_cmd", bus.cmd, 16'hA53C);
    check("nom_cmd_rdy", bus.cmd_rdy, 1'b1);
    wait_cycles(30);
    check("nom_cmd_rdy_holds", bus.cmd_rdy, 1'b1);
    check("nom_no_frm_err", frm_cnt, 0);
    bus.clr_cmd_rdy = 1'b1;
    wait_cycles(1);
    bus.clr_cmd_rdy = 1'b0;
    check("clr_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("clr_keeps_cmd", bus.cmd, 16'hA53C);

    // Glitch rejection: 4-clock low pulse
    r0 = rise_cnt;
    RX = 1'b0;
    wait_cycles(4);
    RX = 1'b1;
    wait_cycles(40);
    check("glitch_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("glitch_no_rise", rise_cnt - r0, 0);
    check("glitch_no_frm_err", frm_cnt, 0);
    send_byte(8'h5A, 1'b1, s);
    send_byte(8'hC3, 1'b1, s);
    wait_cycles(10);
    check("glitch_then_cmd", bus.cmd, 16'h5AC3);

    // Framing error on the low byte
    f0 = frm_cnt;
    send_byte(8'h12, 1'b1, s);
    send_byte(8'h34, 1'b0, s);
    send_byte(8'h56, 1'b1, s);
    wait_cycles(10);
    check("frm_err_once", frm_cnt - f0, 1);
    check("frm_cmd", bus.cmd, 16'h1256);
    check("frm_cmd_rdy", bus.cmd_rdy, 1'b1);

    // New high byte clears cmd_rdy but leaves cmd alone
    send_byte(8'h9A, 1'b1, s);
    wait_cycles(5);
    check("hi_clears_rdy", bus.cmd_rdy, 1'b0);
    check("hi_keeps_cmd", bus.cmd, 16'h1256);

    // Clear held through the set cycle: set wins for that cycle
    h0 = rdy_high_cnt;
    bus.clr_cmd_rdy = 1'b1;
    send_byte(8'hBC, 1'b1, s);
    wait_cycles(10);
    bus.clr_cmd_rdy = 1'b0;
    wait_cycles(2);
    check("set_wins_one_cycle", rdy_high_cnt - h0, 1);
    check("set_wins_cmd", bus.cmd, 16'h9ABC);
    check("set_wins_then_clr", bus.cmd_rdy, 1'b0);

    // Reset during data bit 4 of a high byte
    @(posedge clk);
    #1;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    RX = 1'b1;
    wait_cycles(BAUD_DIV / 2);
    rst_n = 1'b0;
    wait_cycles(3);
    check("midrst_cmd", bus.cmd, 16'h0000);
    check("midrst_cmd_rdy", bus.cmd_rdy, 1'b0);
    rst_n = 1'b1;
    wait_cycles(20);
    send_byte(8'h01, 1'b1, s);
    send_byte(8'h02, 1'b1, s);
    wait_cycles(10);
    check("midrst_new_cmd", bus.cmd, 16'h0102);
    check("midrst_new_rdy", bus.cmd_rdy, 1'b1);

    // Inter-byte timeout scenario
`ifdef UART_CMD_TIMEOUT_EN
    exp_to  = 1;
    exp_cmd = 16'h8899;
    exp_rdy = 1'b1;
`else
    exp_to  = 0;
    exp_cmd = 16'h7788;
    exp_rdy = 1'b0;
`endif
    f0 = frm_cnt;
    send_byte(8'h77, 1'b1, s);
    wait_cycles(250);
    check("to_frm_err", frm_cnt - f0, exp_to);
    send_byte(8'h88, 1'b1, s);
    send_byte(8'h99, 1'b1, s);
    wait_cycles(10);
    check("to_cmd", bus.cmd, exp_cmd);
    check("to_cmd_rdy", bus.cmd_rdy, exp_rdy);
    check("to_frm_total", frm_cnt - f0, exp_to);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
